// File: rtl/turn_arbiter_if.sv
// Command handshake between the turn arbiter (master) and the board/cursor
// controller (slave).
interface turn_arbiter_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_player;
    logic       place_ok;

    modport master (
        output cmd_valid, cmd_op, cmd_player,
        input  cmd_ready, place_ok
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_player,
        output cmd_ready, place_ok
    );
endinterface

// File: rtl/turn_arbiter.sv
// Turn arbiter: forwards the active player's presses to the board as valid/ready
// commands. Define TURN_TIMEOUT_EN to build the idle-turn forfeit timer.
module turn_arbiter #(
    parameter int unsigned TIMEOUT_TICKS = 600,
    parameter int unsigned CNT_W         = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick_i,
    input  logic           first_player_i,
    input  logic [4:0]     p1_btn_i,
    input  logic [4:0]     p2_btn_i,
    input  logic           game_over_i,
    turn_arbiter_if.master cmd_if,
    output logic           turn_o,
    output logic           timeout_pulse_o,
    output logic           done_o
);
    typedef enum logic [2:0] {IDLE, WAIT_PRESS, ISSUE, WAIT_RELEASE, DONE} state_e;
    localparam logic [2:0] OP_PLACE = 3'd4;

    state_e     state_q;
    logic       cmd_valid_q;
    logic       cmd_player_q;
    logic [2:0] cmd_op_q;
    logic       turn_q;
    logic       done_q;
    logic       go_pend_q;
    logic [4:0] act_btn;
    logic [4:0] own_btn;
    logic       accept;
    logic       place_accept;
    logic       timeout_hit;

    // Buttons layout {sel, up, down, left, right}; sel has highest priority.
    function automatic logic [2:0] encode_op(input logic [4:0] b);
        if (b[4])      return 3'd4;
        else if (b[3]) return 3'd0;
        else if (b[2]) return 3'd1;
        else if (b[1]) return 3'd2;
        else           return 3'd3;
    endfunction

    assign act_btn      = turn_q ? p2_btn_i : p1_btn_i;
    assign own_btn      = cmd_player_q ? p2_btn_i : p1_btn_i;
    assign accept       = (state_q == ISSUE) && cmd_if.cmd_ready;
    assign place_accept = accept && (cmd_op_q == OP_PLACE) && cmd_if.place_ok;

`ifdef TURN_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             count_en;
    logic             cnt_clr;
    logic             tpulse_q;

    // Counting stops in ISSUE; game_over pre-empts a same-cycle forfeit.
    assign count_en    = tick_i && !game_over_i &&
                         ((state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE));
    assign timeout_hit = count_en && (cnt_q >= CNT_W'(TIMEOUT_TICKS - 1));
    assign cnt_clr     = (state_q == IDLE) || place_accept || timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            tpulse_q <= 1'b0;
        end else begin
            tpulse_q <= timeout_hit;
            if (cnt_clr)
                cnt_q <= '0;
            else if (count_en && (cnt_q < CNT_W'(TIMEOUT_TICKS)))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_pulse_o = tpulse_q;
`else
    logic unused_cfg;
    assign unused_cfg      = ^{tick_i, CNT_W'(TIMEOUT_TICKS)};
    assign timeout_hit     = 1'b0;
    assign timeout_pulse_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_valid_q  <= 1'b0;
            cmd_player_q <= 1'b0;
            cmd_op_q     <= '0;
            turn_q       <= 1'b0;
            done_q       <= 1'b0;
            go_pend_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    turn_q    <= first_player_i;
                    go_pend_q <= 1'b0;
                    state_q   <= WAIT_PRESS;
                end
                WAIT_PRESS: begin
                    if (game_over_i) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        turn_q <= ~turn_q;
                    end else if (|act_btn) begin
                        cmd_op_q     <= encode_op(act_btn);
                        cmd_player_q <= turn_q;
                        cmd_valid_q  <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // game_over seen mid-handshake is held until the accept.
                    if (game_over_i)
                        go_pend_q <= 1'b1;
                    if (accept) begin
                        cmd_valid_q <= 1'b0;
                        if (place_accept)
                            turn_q <= ~turn_q;
                        if (game_over_i || go_pend_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= WAIT_RELEASE;
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (game_over_i) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (timeout_hit) begin
                        turn_q  <= ~turn_q;
                        state_q <= WAIT_PRESS;
                    end else if (~|own_btn) begin
                        state_q <= WAIT_PRESS;
                    end
                end
                DONE: begin
                    cmd_valid_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                default: begin
                    cmd_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                    go_pend_q   <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_if.cmd_valid  = cmd_valid_q;
    assign cmd_if.cmd_op     = cmd_op_q;
    assign cmd_if.cmd_player = cmd_player_q;
    assign turn_o            = turn_q;
    assign done_o            = done_q;
endmodule

// File: tb/tb_turn_arbiter.sv
// Self-checking bench for turn_arbiter: vector table of presses plus directed
// sequences for reset, game_over and timeout corners.
module tb_turn_arbiter;
    localparam int unsigned TT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       first_player;
    logic       game_over;
    logic [4:0] p1_btn;
    logic [4:0] p2_btn;
    logic       turn;
    logic       tpulse;
    logic       done;

    turn_arbiter_if bus ();

    turn_arbiter #(.TIMEOUT_TICKS(TT), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick_i         (tick),
        .first_player_i (first_player),
        .p1_btn_i       (p1_btn),
        .p2_btn_i       (p2_btn),
        .game_over_i    (game_over),
        .cmd_if         (bus),
        .turn_o         (turn),
        .timeout_pulse_o(tpulse),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pl;
        logic [4:0]  btn;
        int unsigned stall;
        logic        pok;
        logic        exp_cmd;
        logic [2:0]  op;
        logic        turn;
    } vec_t;

    vec_t        vt[13];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_pulse = 0;
    logic [3:0]  sb[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted command must match the oldest expectation.
    always @(negedge clk) begin
        if (tpulse === 1'b1)
            n_pulse++;
        if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
            if (sb.size() == 0)
                check("unexpected_cmd", {4'd0, bus.cmd_op, bus.cmd_player}, 8'hff);
            else
                check("cmd_op_player", {4'd0, bus.cmd_op, bus.cmd_player}, {4'd0, sb.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic pl, input logic [4:0] b);
        if (pl) p2_btn = b;
        else    p1_btn = b;
    endtask

    task automatic do_reset(input logic fp);
        rst           = 1'b1;
        first_player  = fp;
        p1_btn        = '0;
        p2_btn        = '0;
        tick          = 1'b0;
        game_over     = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.place_ok  = 1'b0;
        sb.delete();
        step(2);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned n;
        logic        saw;
        bus.cmd_ready = (v.stall == 0);
        bus.place_ok  = (v.stall == 0) ? v.pok : ~v.pok;
        set_btn(v.pl, v.btn);
        if (v.exp_cmd) begin
            sb.push_back({v.op, v.pl});
            n   = 0;
            saw = 1'b0;
            while (!saw && n < 8) begin
                @(negedge clk);
                saw = bus.cmd_valid;
                n++;
            end
            if (!saw) begin
                check("valid_rise", {7'd0, bus.cmd_valid}, 8'd1);
                void'(sb.pop_back());
            end else begin
                for (int unsigned i = 0; i < v.stall; i++) begin
                    step(1);
                    check("valid_hold", {4'd0, bus.cmd_valid, bus.cmd_op}, {4'd0, 1'b1, v.op});
                end
                bus.cmd_ready = 1'b1;
                bus.place_ok  = v.pok;
                step(1);
                check("valid_drop", {7'd0, bus.cmd_valid}, 8'd0);
                check("turn_after_accept", {7'd0, turn}, {7'd0, v.turn});
            end
            step(10);
        end else begin
            bus.cmd_ready = 1'b1;
            step(20);
            check("ignored_valid", {7'd0, bus.cmd_valid}, 8'd0);
        end
        set_btn(v.pl, 5'd0);
        bus.cmd_ready = 1'b0;
        step(3);
        check("turn", {7'd0, turn}, {7'd0, v.turn});
        check("not_done", {7'd0, done}, 8'd0);
    endtask

    initial begin
        int unsigned p0;
        //          pl    btn       stall pok   cmd   op    turn
        vt[0]  = '{1'b1, 5'b01000, 0, 1'b0, 1'b1, 3'd0, 1'b1};
        vt[1]  = '{1'b0, 5'b10000, 0, 1'b0, 1'b0, 3'd0, 1'b1};
        vt[2]  = '{1'b1, 5'b10000, 5, 1'b1, 1'b1, 3'd4, 1'b0};
        vt[3]  = '{1'b1, 5'b10000, 0, 1'b1, 1'b0, 3'd0, 1'b0};
        vt[4]  = '{1'b0, 5'b10000, 5, 1'b1, 1'b1, 3'd4, 1'b1};
        vt[5]  = '{1'b1, 5'b10100, 2, 1'b0, 1'b1, 3'd4, 1'b1};
        vt[6]  = '{1'b1, 5'b10000, 0, 1'b0, 1'b1, 3'd4, 1'b1};
        vt[7]  = '{1'b1, 5'b00111, 1, 1'b1, 1'b1, 3'd1, 1'b1};
        vt[8]  = '{1'b1, 5'b00011, 0, 1'b1, 1'b1, 3'd2, 1'b1};
        vt[9]  = '{1'b1, 5'b00001, 3, 1'b1, 1'b1, 3'd3, 1'b1};
        vt[10] = '{1'b1, 5'b01010, 0, 1'b1, 1'b1, 3'd0, 1'b1};
        vt[11] = '{1'b1, 5'b10000, 0, 1'b1, 1'b1, 3'd4, 1'b0};
        vt[12] = '{1'b0, 5'b00001, 1, 1'b0, 1'b1, 3'd3, 1'b0};

        // Reset values, checked while rst is still asserted.
        rst           = 1'b1;
        first_player  = 1'b1;
        p1_btn        = '0;
        p2_btn        = '0;
        tick          = 1'b0;
        game_over     = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.place_ok  = 1'b0;
        step(2);
        check("rst_valid",  {7'd0, bus.cmd_valid},  8'd0);
        check("rst_op",     {5'd0, bus.cmd_op},     8'd0);
        check("rst_player", {7'd0, bus.cmd_player}, 8'd0);
        check("rst_turn",   {7'd0, turn},           8'd0);
        check("rst_tpulse", {7'd0, tpulse},         8'd0);
        check("rst_done",   {7'd0, done},           8'd0);
        rst = 1'b0;

        foreach (vt[i])
            run_vec(vt[i]);
        check("sb_drained", 8'(sb.size()), 8'd0);

        // Asynchronous reset mid-handshake.
        do_reset(1'b0);
        set_btn(1'b0, 5'b01000);
        step(3);
        check("pre_rst_valid", {7'd0, bus.cmd_valid}, 8'd1);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", {7'd0, bus.cmd_valid}, 8'd0);
        step(1);
        rst    = 1'b0;
        p1_btn = '0;

        // game_over pulsed during ISSUE: handshake completes, then DONE.
        do_reset(1'b0);
        sb.push_back({3'd3, 1'b0});
        set_btn(1'b0, 5'b00001);
        step(3);
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        step(1);
        check("go_issue_valid", {7'd0, bus.cmd_valid}, 8'd1);
        check("go_issue_done",  {7'd0, done},          8'd0);
        bus.cmd_ready = 1'b1;
        step(1);
        check("go_after_valid", {7'd0, bus.cmd_valid}, 8'd0);
        check("go_after_done",  {7'd0, done},          8'd1);
        p1_btn = '0;
        step(2);
        p1_btn = 5'b10000;
        p2_btn = 5'b10000;
        step(10);
        check("done_sticky", {7'd0, done}, 8'd1);
        check("done_sb", 8'(sb.size()), 8'd0);

        // game_over and a press in the same WAIT_PRESS cycle: no command.
        do_reset(1'b1);
        step(1);
        p2_btn        = 5'b01000;
        game_over     = 1'b1;
        bus.cmd_ready = 1'b1;
        step(1);
        game_over = 1'b0;
        check("go_press_done", {7'd0, done}, 8'd1);
        step(5);
        check("go_press_valid", {7'd0, bus.cmd_valid}, 8'd0);

        // Idle-turn timeout.
        do_reset(1'b0);
        step(1);
        p0 = n_pulse;
`ifdef TURN_TIMEOUT_EN
        repeat (TT) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(1);
        end
        check("to_pulses", 8'(n_pulse - p0), 8'd1);
        check("to_turn",   {7'd0, turn},     8'd1);
        step(5);
        check("to_single", 8'(n_pulse - p0), 8'd1);
        repeat (TT) begin
            tick = 1'b1;
            step(1);
        end
        tick = 1'b0;
        step(1);
        check("to_pulses2", 8'(n_pulse - p0), 8'd2);
        check("to_turn2",   {7'd0, turn},     8'd0);
`else
        tick = 1'b1;
        step(1000);
        tick = 1'b0;
        step(1);
        check("no_to_pulses", 8'(n_pulse - p0),  8'd0);
        check("no_to_turn",   {7'd0, turn},      8'd0);
        check("no_to_valid",  {7'd0, bus.cmd_valid}, 8'd0);
`endif
        check("to_done", {7'd0, done}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/turn_arbiter.md
# turn_arbiter

Shares the single tic-tac-toe board and cursor datapath between two player button ports. Only the player whose turn it is reaches the board; all others are ignored. Each qualified press becomes one registered command (cursor move or place) on a valid/ready handshake toward the board controller. The block hands the turn over on an accepted placement or, optionally, on an idle timeout. It sits between the debounced button synchronisers and the board/cursor controller.

## Interface
- TIMEOUT_TICKS, 600: idle `tick` count before the turn is forfeited; must be ≥1.
- CNT_W, 10: timeout counter width; requires TIMEOUT_TICKS < 2^CNT_W.

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle enable used only for timeout counting
- first_player  in  1  starting player (0 = P1, 1 = P2), sampled in IDLE
- p1_btn  in  5  P1 buttons {sel, up, down, left, right}, synchronised, level
- p2_btn  in  5  P2 buttons, same layout
- cmd_ready  in  1  board accepts the command this cycle
- place_ok  in  1  placement legal; sampled only with an accepted place command
- game_over  in  1  win or draw detected by the board
- cmd_valid  out  1  command pending
- cmd_op  out  3  0 up, 1 down, 2 left, 3 right, 4 place
- cmd_player  out  1  player issuing the command
- turn  out  1  current player
- timeout_pulse  out  1  one-cycle pulse on forfeit
- done  out  1  high in DONE

## Operation
- States: IDLE, WAIT_PRESS, ISSUE, WAIT_RELEASE, DONE.
- IDLE: load turn ← first_player, clear the counter, go to WAIT_PRESS the next cycle.
- WAIT_PRESS: watch only the turn player's buttons.
  - On any nonzero button, capture cmd_op by priority sel > up > down > left > right.
  - Set cmd_player ← turn and go to ISSUE.
- ISSUE: cmd_valid = 1. cmd_op and cmd_player stay stable until cmd_valid & cmd_ready.
  - On accept, go to WAIT_RELEASE.
  - If cmd_op = 4 and place_ok = 1 at accept, toggle turn and clear the counter.
- WAIT_RELEASE: wait until all 5 buttons of cmd_player are 0, then return to WAIT_PRESS.
- game_over = 1 in WAIT_PRESS or WAIT_RELEASE sends the block to DONE.
- game_over = 1 in ISSUE: finish the handshake first, then go to DONE instead of WAIT_RELEASE.
- DONE: cmd_valid = 0 and done = 1. Leave only through rst.
- Any other state encoding recovers to IDLE.
- The inactive player's buttons never cause a command or a state change, in any state.

## Timing
- Reset values: every output is 0, turn = 0, counter = 0, state = IDLE.
- A press visible at edge N drives cmd_valid high after edge N+1 (one-cycle latency).
- A command accepted at edge M:
  - cmd_valid is low after edge M+1.
  - turn is updated after edge M+1.
  - at most one command per press.
- A held button produces exactly one command.
- A new command needs a full release first, even after the turn changes.
- Asserting rst in mid-handshake drops cmd_valid immediately (asynchronous clear).
- When game_over and a press arrive in the same cycle in WAIT_PRESS, game_over wins: go to DONE, issue no command.

## Configuration
- TURN_TIMEOUT_EN defined:
  - In WAIT_PRESS and WAIT_RELEASE, the counter increments on each tick, saturating at TIMEOUT_TICKS.
  - Reaching TIMEOUT_TICKS toggles turn, pulses timeout_pulse for one cycle, clears the counter and goes to WAIT_PRESS.
  - The counter holds in ISSUE.
- TURN_TIMEOUT_EN undefined:
  - No counter logic is built.
  - timeout_pulse is tied to 0.
  - A turn never expires.

## Test plan
- Reset with first_player = 1, P2 presses up while cmd_ready = 1 → after 2 clocks, one cycle of cmd_valid = 1 with cmd_op = 0 and cmd_player = 1; turn stays 1.
- P1's turn, P2 holds sel for 20 cycles → cmd_valid stays 0 and state stays WAIT_PRESS.
- P1 presses sel, cmd_ready held 0 for 5 cycles then 1 with place_ok = 1 → cmd_valid high 6 cycles with stable op 4; turn becomes 1; P1 holds sel afterwards → no second command.
- Place accepted with place_ok = 0 → turn unchanged; after release and a new sel, cmd_op = 4 is issued again.
- game_over raised during ISSUE → handshake completes, then done = 1; later presses are ignored until rst.
- With TURN_TIMEOUT_EN, TIMEOUT_TICKS = 3, three ticks and no press → timeout_pulse for one cycle and turn toggles; without the macro, 1000 ticks → no change.
